// File: rtl/bk_ps2_keyboard_if.sv
// ---------------------------------------------------------------------------
// bk_ps2_keyboard_if : PS/2 lines, core read strobe and keyboard outputs
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface bk_ps2_keyboard_if;
  logic       ps2_clk;
  logic       ps2_dat;
  logic       read_kbd;
  logic       kbd_available;
  logic [7:0] kbd_data;
  logic       kbd_ar2;
  logic       stopkey;
  logic       keydown;
  logic       frame_err;

  modport master (
    output ps2_clk, ps2_dat, read_kbd,
    input  kbd_available, kbd_data, kbd_ar2, stopkey, keydown, frame_err
  );

  modport slave (
    input  ps2_clk, ps2_dat, read_kbd,
    output kbd_available, kbd_data, kbd_ar2, stopkey, keydown, frame_err
  );
endinterface

`default_nettype wire

// File: rtl/bk_ps2_keyboard.sv
// ---------------------------------------------------------------------------
// bk_ps2_keyboard : PS/2 set-2 receiver, KOI-7 translation and key-code FIFO
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bk_ps2_keyboard #(
  parameter int DEPTH   = 4,
  parameter int FILT    = 4,
  parameter int TIMEOUT = 20000
) (
  input  wire logic          clk,
  input  wire logic          reset_n,
  input  wire logic          ce,
  bk_ps2_keyboard_if.slave   kbd
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = $clog2(FILT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;
  localparam logic [1:0] S_PAR  = 2'd2;
  localparam logic [1:0] S_STOP = 2'd3;

  // ---------------- input synchronisers and glitch filters ----------------
  logic [1:0] raw;
  logic [1:0] filt;
  assign raw = {kbd.ps2_dat, kbd.ps2_clk};

  for (genvar i = 0; i < 2; i++) begin : g_line
    logic          s1, s2, f;
    logic [FW-1:0] cnt;
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        s1 <= 1'b1; s2 <= 1'b1; f <= 1'b1; cnt <= '0;
      end else if (ce) begin
        s1 <= raw[i];
        s2 <= s1;
        if (s2 == f)                   cnt <= '0;
        else if (cnt == FW'(FILT - 1)) begin f <= s2; cnt <= '0; end
        else                           cnt <= cnt + 1'b1;
      end
    end
    assign filt[i] = f;
  end

  logic clk_prev, strobe, dat;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  clk_prev <= 1'b1;
    else if (ce)   clk_prev <= filt[0];
  end
  assign strobe = ce & clk_prev & ~filt[0];
  assign dat    = filt[1];

  // ---------------- frame FSM ----------------
  logic [1:0]    state, state_nx;
  logic [2:0]    bitcnt;
  logic [7:0]    shreg;
  logic          par_ok;
  logic [TW-1:0] tocnt;
  logic          timeout, byte_valid, frame_err_w;

  assign timeout = ce & ~strobe & (state != S_IDLE) & (tocnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (timeout) state_nx = S_IDLE;
    else if (strobe) begin
      case (state)
        S_IDLE:  if (!dat) state_nx = S_DATA;
        S_DATA:  if (bitcnt == 3'd7) state_nx = S_PAR;
        S_PAR:   state_nx = S_STOP;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_comb begin
    byte_valid  = 1'b0;
    frame_err_w = timeout;
    if (strobe && state == S_STOP) begin
      if (par_ok && dat) byte_valid  = 1'b1;
      else               frame_err_w = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bitcnt <= '0; shreg <= '0; par_ok <= 1'b0; tocnt <= '0;
    end else if (ce) begin
      tocnt <= (state == S_IDLE || strobe) ? '0 : tocnt + 1'b1;
      if (strobe) begin
        if (state == S_IDLE) bitcnt <= '0;
        if (state == S_DATA) begin
          shreg  <= {dat, shreg[7:1]};
          bitcnt <= bitcnt + 1'b1;
        end
        // odd parity: data ones plus parity bit must be odd
        if (state == S_PAR) par_ok <= (^shreg) ^ dat;
      end
    end
  end

  // ---------------- prefix tracking and translation ----------------
  function automatic logic [7:0] xlate(input logic e, input logic [7:0] c);
    logic [7:0] r;
    r = 8'h00;
    if (e) begin
      case (c)
        8'h6B: r = {1'b1, 7'h08};  8'h74: r = {1'b1, 7'h19};
        8'h75: r = {1'b1, 7'h1A};  8'h72: r = {1'b1, 7'h1B};
        default: r = 8'h00;
      endcase
    end else begin
      case (c)
        8'h1C: r = {1'b1, 7'h41};  8'h32: r = {1'b1, 7'h42};  8'h21: r = {1'b1, 7'h43};
        8'h23: r = {1'b1, 7'h44};  8'h24: r = {1'b1, 7'h45};  8'h2B: r = {1'b1, 7'h46};
        8'h34: r = {1'b1, 7'h47};  8'h33: r = {1'b1, 7'h48};  8'h43: r = {1'b1, 7'h49};
        8'h3B: r = {1'b1, 7'h4A};  8'h42: r = {1'b1, 7'h4B};  8'h4B: r = {1'b1, 7'h4C};
        8'h3A: r = {1'b1, 7'h4D};  8'h31: r = {1'b1, 7'h4E};  8'h44: r = {1'b1, 7'h4F};
        8'h4D: r = {1'b1, 7'h50};  8'h15: r = {1'b1, 7'h51};  8'h2D: r = {1'b1, 7'h52};
        8'h1B: r = {1'b1, 7'h53};  8'h2C: r = {1'b1, 7'h54};  8'h3C: r = {1'b1, 7'h55};
        8'h2A: r = {1'b1, 7'h56};  8'h1D: r = {1'b1, 7'h57};  8'h22: r = {1'b1, 7'h58};
        8'h35: r = {1'b1, 7'h59};  8'h1A: r = {1'b1, 7'h5A};
        8'h45: r = {1'b1, 7'h30};  8'h16: r = {1'b1, 7'h31};  8'h1E: r = {1'b1, 7'h32};
        8'h26: r = {1'b1, 7'h33};  8'h25: r = {1'b1, 7'h34};  8'h2E: r = {1'b1, 7'h35};
        8'h36: r = {1'b1, 7'h36};  8'h3D: r = {1'b1, 7'h37};  8'h3E: r = {1'b1, 7'h38};
        8'h46: r = {1'b1, 7'h39};
        8'h29: r = {1'b1, 7'h20};  8'h5A: r = {1'b1, 7'h0A};  8'h66: r = {1'b1, 7'h18};
        8'h0D: r = {1'b1, 7'h0D};  8'h76: r = {1'b1, 7'h03};
        default: r = 8'h00;
      endcase
    end
    return r;
  endfunction

  logic       ext, brk, ar2, stop, held;
  logic [8:0] last_make;
  logic [7:0] map;
  logic       is_e0, is_f0, is_ign, evt, lvl_alt, lvl_f12, push;

  assign map     = xlate(ext, shreg);
  assign is_e0   = shreg == 8'hE0;
  assign is_f0   = shreg == 8'hF0;
  assign is_ign  = shreg == 8'hE1 || shreg == 8'hAA || shreg == 8'hFA;
  assign evt     = byte_valid & ~is_e0 & ~is_f0 & ~is_ign;
  assign lvl_alt = ~ext & (shreg == 8'h11);
  assign lvl_f12 = ~ext & (shreg == 8'h07);
  assign push    = evt & ~brk & map[7];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ext <= 1'b0; brk <= 1'b0; ar2 <= 1'b0; stop <= 1'b0; held <= 1'b0;
      last_make <= '0;
    end else if (byte_valid) begin
      if (is_e0)      ext <= 1'b1;
      else if (is_f0) brk <= 1'b1;
      else if (!is_ign) begin
        ext <= 1'b0;
        brk <= 1'b0;
        if (lvl_alt)      ar2  <= ~brk;
        else if (lvl_f12) stop <= ~brk;
        else if (!brk && map[7]) begin
          last_make <= {ext, shreg};
          held      <= 1'b1;
        end else if (brk && {ext, shreg} == last_make) held <= 1'b0;
      end
    end
  end

  // ---------------- key-code FIFO ----------------
  logic [6:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  logic          read_prev, pop, wr_ok;

  assign pop   = ce & read_prev & ~kbd.read_kbd & (count != '0);
  assign wr_ok = push & ((count != (AW+1)'(DEPTH)) | pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      read_prev <= 1'b0; rd_ptr <= '0; wr_ptr <= '0; count <= '0;
    end else begin
      if (ce)    read_prev <= kbd.read_kbd;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, wr_ok} - {{AW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= map[6:0];
  end

  assign kbd.kbd_available = count != '0;
  assign kbd.kbd_data      = (count != '0) ? {1'b0, mem[rd_ptr]} : 8'h00;
  assign kbd.kbd_ar2       = ar2;
  assign kbd.stopkey       = stop;
  assign kbd.keydown       = held;
  assign kbd.frame_err     = frame_err_w;

endmodule

`default_nettype wire

// File: tb/tb_bk_ps2_keyboard.sv
// ---------------------------------------------------------------------------
// tb_bk_ps2_keyboard : directed self-checking bench for bk_ps2_keyboard
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_bk_ps2_keyboard;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic ce = 1'b1;
  int   passes = 0;
  int   checks = 0;
  int   err_cnt = 0;
  int   e0;

  bk_ps2_keyboard_if kif ();

  bk_ps2_keyboard #(.DEPTH(4), .FILT(4), .TIMEOUT(20000)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .ce      (ce),
    .kbd     (kif)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (kif.frame_err === 1'b1) err_cnt++;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic ps2_bit(input logic b);
    kif.ps2_dat = b;
    cyc(8);
    kif.ps2_clk = 1'b0;
    cyc(10);
    kif.ps2_clk = 1'b1;
    cyc(2);
  endtask

  function automatic logic [10:0] frame(input logic [7:0] b, input logic badpar);
    return {1'b1, (~^b) ^ badpar, b, 1'b0};
  endfunction

  task automatic send(input logic [7:0] b, input logic badpar);
    logic [10:0] f;
    f = frame(b, badpar);
    for (int i = 0; i < 11; i++) ps2_bit(f[i]);
    kif.ps2_dat = 1'b1;
    cyc(12);
  endtask

  task automatic pulse_read();
    kif.read_kbd = 1'b1;
    cyc(2);
    kif.read_kbd = 1'b0;
    cyc(2);
  endtask

  initial begin
    logic [10:0] pf;
    kif.ps2_clk = 1'b1;
    kif.ps2_dat = 1'b1;
    kif.read_kbd = 1'b0;
    cyc(3);
    chk("rst_avail", 32'(kif.kbd_available), 32'd0);
    chk("rst_data",  32'(kif.kbd_data),      32'd0);
    chk("rst_ar2",   32'(kif.kbd_ar2),       32'd0);
    chk("rst_stop",  32'(kif.stopkey),       32'd0);
    chk("rst_kdown", 32'(kif.keydown),       32'd0);
    chk("rst_ferr",  32'(kif.frame_err),     32'd0);
    reset_n = 1'b1;
    cyc(2);

    // make A, then break A
    send(8'h1C, 1'b0);
    chk("a_avail", 32'(kif.kbd_available), 32'd1);
    chk("a_data",  32'(kif.kbd_data),      32'h41);
    chk("a_kdown", 32'(kif.keydown),       32'd1);
    send(8'hF0, 1'b0);
    send(8'h1C, 1'b0);
    chk("brk_kdown", 32'(kif.keydown),       32'd0);
    chk("brk_avail", 32'(kif.kbd_available), 32'd1);

    // long register access keeps the head stable, pop on release
    kif.read_kbd = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      chk("hold_data", 32'(kif.kbd_data), 32'h41);
    end
    kif.read_kbd = 1'b0;
    cyc(1);
    chk("pop_avail", 32'(kif.kbd_available), 32'd0);

    // extended up-arrow then Enter
    send(8'hE0, 1'b0);
    send(8'h75, 1'b0);
    send(8'h5A, 1'b0);
    chk("up_data", 32'(kif.kbd_data), 32'h1A);
    pulse_read();
    chk("ent_data", 32'(kif.kbd_data), 32'h0A);
    pulse_read();
    chk("ext_empty", 32'(kif.kbd_available), 32'd0);

    // overflow: six makes into a four-deep FIFO
    repeat (6) send(8'h1C, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("ovf_avail", 32'(kif.kbd_available), 32'd1);
      chk("ovf_data",  32'(kif.kbd_data),      32'h41);
      pulse_read();
    end
    pulse_read();
    chk("ovf_empty", 32'(kif.kbd_available), 32'd0);
    chk("ovf_data0", 32'(kif.kbd_data),      32'd0);

    // parity error
    e0 = err_cnt;
    send(8'h1C, 1'b1);
    chk("par_err",   32'(err_cnt - e0),       32'd1);
    chk("par_nopsh", 32'(kif.kbd_available),  32'd0);

    // truncated frame times out
    e0 = err_cnt;
    pf = frame(8'h1C, 1'b0);
    for (int i = 0; i < 5; i++) ps2_bit(pf[i]);
    cyc(19900);
    chk("to_early", 32'(err_cnt - e0), 32'd0);
    cyc(200);
    chk("to_err",   32'(err_cnt - e0), 32'd1);
    send(8'h29, 1'b0);
    chk("to_space", 32'(kif.kbd_data), 32'h20);
    pulse_read();

    // level keys
    send(8'h11, 1'b0);
    chk("alt_ar2",   32'(kif.kbd_ar2),       32'd1);
    chk("alt_nopsh", 32'(kif.kbd_available), 32'd0);
    send(8'h07, 1'b0);
    chk("f12_stop", 32'(kif.stopkey), 32'd1);
    send(8'hF0, 1'b0);
    send(8'h07, 1'b0);
    chk("f12_rel",  32'(kif.stopkey), 32'd0);
    chk("alt_keep", 32'(kif.kbd_ar2), 32'd1);

    // asynchronous reset in the middle of a frame
    send(8'h1C, 1'b0);
    chk("pre_avail", 32'(kif.kbd_available), 32'd1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_avail", 32'(kif.kbd_available), 32'd0);
    chk("ar_data",  32'(kif.kbd_data),      32'd0);
    chk("ar_ar2",   32'(kif.kbd_ar2),       32'd0);
    chk("ar_stop",  32'(kif.stopkey),       32'd0);
    chk("ar_kdown", 32'(kif.keydown),       32'd0);
    cyc(2);
    reset_n = 1'b1;
    cyc(2);
    e0 = err_cnt;
    send(8'h29, 1'b0);
    chk("post_data", 32'(kif.kbd_data),  32'h20);
    chk("post_err",  32'(err_cnt - e0),  32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

`default_nettype wire
